// File: rtl/rb_drain_seq_pkg.sv
// Shared definitions for the reduce-buffer drain sequencer: default
// parameters, FSM state encoding and the burst-length clamp helper.
package rb_drain_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH        = 64;
    localparam int unsigned DEF_ADDR_WIDTH        = 12;
    localparam int unsigned DEF_POWER_WIDTH       = 4;
    localparam int unsigned DEF_BRAM_READ_LATENCY = 2;
    // Skid entries beyond the read latency: one for the word on the output, one of slack.
    localparam int unsigned DEF_FIFO_SLACK        = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    // A burst can never be longer than the address space it walks.
    function automatic int unsigned eff_power(input int unsigned n, input int unsigned aw);
        return (n > aw) ? aw : n;
    endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is presented
// directly from storage and reads as zero while the FIFO is empty.
module sync_fwft_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop_c  = pop_i && (count_q != '0);
        do_push_c = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_c);
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push_c && !do_pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop_c && !do_push_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/rb_drain_seq.sv
// Streams a 2^n-word burst out of the reduce buffer: issues credit-limited
// BRAM reads, tracks them through the read latency and drains a skid FIFO.
module rb_drain_seq
    import rb_drain_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int unsigned POWER_WIDTH       = DEF_POWER_WIDTH,
    parameter int unsigned BRAM_READ_LATENCY = DEF_BRAM_READ_LATENCY,
    parameter int unsigned FIFO_DEPTH        = BRAM_READ_LATENCY + DEF_FIFO_SLACK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_start,
    input  logic [POWER_WIDTH-1:0]  i_n,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    output logic                    o_rden_rb,
    output logic [ADDR_WIDTH-1:0]   o_rdaddr_rb,
    input  logic [4*DATA_WIDTH-1:0] i_data_rb,
    output logic [4*DATA_WIDTH-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int unsigned WORD_W = 4 * DATA_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W   = $clog2(FIFO_DEPTH + BRAM_READ_LATENCY + 2) + 1;

    drain_state_e                 state_q;
    logic [ADDR_WIDTH-1:0]        base_q;
    logic [CNT_W-1:0]             total_q;
    logic [CNT_W-1:0]             issue_cnt_q;
    logic [CNT_W-1:0]             xfer_cnt_q;
    logic                         rden_q;
    logic [ADDR_WIDTH-1:0]        rdaddr_q;
    logic [BRAM_READ_LATENCY-1:0] tag_q;
    logic                         busy_q;
    logic                         done_q;

    logic                         fifo_valid;
    logic [WORD_W-1:0]            fifo_data;
    logic [OCC_W-1:0]             fifo_cnt;
    logic                         push_c;
    logic                         pop_c;
    logic                         issue_c;
    logic                         last_word_c;
    logic [CR_W-1:0]              committed_c;

    // Reads already committed to the FIFO: words held plus reads in flight,
    // less the word leaving this cycle, so steady state sustains one per cycle.
    always_comb begin
        committed_c = CR_W'(fifo_cnt) + CR_W'(rden_q);
        for (int i = 0; i < int'(BRAM_READ_LATENCY); i++) begin
            committed_c = committed_c + CR_W'(tag_q[i]);
        end
        if (pop_c) begin
            committed_c = committed_c - CR_W'(1);
        end
    end

    always_comb begin
        pop_c       = fifo_valid && i_ready;
        push_c      = tag_q[BRAM_READ_LATENCY-1];
        last_word_c = (xfer_cnt_q == total_q - CNT_W'(1));
        issue_c     = (state_q == ST_READ) && i_en && (committed_c < CR_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            total_q     <= '0;
            issue_cnt_q <= '0;
            xfer_cnt_q  <= '0;
            rden_q      <= 1'b0;
            rdaddr_q    <= '0;
            tag_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rden_q   <= issue_c;
            tag_q[0] <= rden_q;
            for (int i = 1; i < int'(BRAM_READ_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            busy_q <= (state_q == ST_READ) || (state_q == ST_DRAIN);
            done_q <= 1'b0;
            if (issue_c) begin
                rdaddr_q <= base_q + issue_cnt_q[ADDR_WIDTH-1:0];
            end
            if (pop_c) begin
                xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        base_q      <= i_base_addr;
                        total_q     <= CNT_W'(1) << eff_power(32'(i_n), ADDR_WIDTH);
                        issue_cnt_q <= '0;
                        xfer_cnt_q  <= '0;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue_c) begin
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                        if (issue_cnt_q == total_q - CNT_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop_c && last_word_c) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fwft_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .data_i  (i_data_rb),
        .pop_i   (pop_c),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign o_rden_rb   = rden_q;
    assign o_rdaddr_rb = rdaddr_q;
    assign o_data      = fifo_data;
    assign o_valid     = fifo_valid;
    assign o_last      = fifo_valid && last_word_c;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule
